approx_taylor_divider: RTL and testbench

Parametrised, handshaked approximate fixed-point divider. It computes q ≈ a/b with a truncated Taylor series of the reciprocal of the normalised divisor, followed by an optional shift-add error correction. It is the successor of the board-level 8-bit divider datapath and sits behind the switch/key front end or any SoC master. Additions over that datapath:

- width and truncation generics
- start/busy/done handshake
- exact power-of-two path
- divide-by-zero handling
- saturation

---
 rtl/approx_div_pkg.sv | 27 ++
 rtl/approx_taylor_divider_lod_normalize.sv | 20 ++
 rtl/approx_taylor_divider.sv | 174 +++++++++++++++++
 tb/tb_approx_taylor_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_div_pkg.sv
// Shared types and helpers for the approximate Taylor-series divider.
package approx_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ITER  = 2'd2,
        S_SCALE = 2'd3
    } state_e;

    function automatic int tw_calc(input int max_t);
        return $clog2(max_t + 1);
    endfunction

    // Right-shift used by the shift-add correction; 0 disables it.
    function automatic logic [2:0] corr_shift(input logic [31:0] t);
        logic [2:0] s;
        case (t)
            32'd0:                s = 3'd4;
            32'd1, 32'd2, 32'd3:  s = 3'd6;
            32'd4, 32'd5, 32'd6:  s = 3'd7;
            default:              s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/approx_taylor_divider_lod_normalize.sv
// Combinational leading-one detector: eb = leading-one position + 1, bn = b left-aligned.
module lod_normalize #(
    parameter  int N    = 8,
    localparam int EB_W = $clog2(N + 1)
) (
    input  logic [N-1:0]    b_i,
    output logic [EB_W-1:0] eb_o,
    output logic [N-1:0]    bn_o
);

    // Highest set bit wins; b = 0 yields eb = 0 and bn = 0.
    always_comb begin
        eb_o = '0;
        for (int i = 0; i < N; i++) begin
            eb_o = b_i[i] ? EB_W'(i + 1) : eb_o;
        end
        bn_o = b_i << (EB_W'(N) - eb_o);
    end

endmodule

// File: rtl/approx_taylor_divider.sv
// Approximate fixed-point divider: truncated Taylor series of 1/bn plus optional shift-add correction.
module approx_taylor_divider
    import approx_div_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int NB    = N,
    parameter  int F_W   = N,
    parameter  int MAX_T = 15,
    localparam int T_W   = tw_calc(MAX_T)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       a,
    input  logic [N-1:0]       b,
    input  logic [T_W-1:0]     cycles,
    input  logic               corr_en,
    output logic               busy,
    output logic               done,
    output logic [N+F_W-1:0]   q,
    output logic               dz,
    output logic               sat,
    output logic               exact
);

    localparam int EB_W = $clog2(N + 1);
    localparam int AW   = N + 2;
    localparam int PW   = 2 * N + 2;
    localparam int SH_W = $clog2(2 * N + 1);
    localparam int QW   = N + F_W;
    localparam logic [N-1:0]   XT_MASK = {N{1'b1}} << (N - NB);
    localparam logic [T_W-1:0] T_MAX   = T_W'(MAX_T);
    localparam logic [PW-1:0]  Q_MAX   = PW'({QW{1'b1}});

    state_e          state_q;
    logic [N-1:0]    a_q, b_q, p_q;
    logic [T_W-1:0]  t_q, cnt_q;
    logic [AW-1:0]   acc_q;
    logic            corr_q, dz_pend_q, exact_pend_q;
    logic            busy_q, done_q, dz_q, sat_q, exact_q;
    logic [QW-1:0]   q_q;

    logic [EB_W-1:0] eb_s;
    logic [N-1:0]    bn_s, xt_s, p_next_s;
    logic            pow2_s;
    logic [2*N-1:0]  prod_it_s;
    logic [PW-1:0]   prod_s, q_raw_s, q_cor_s;
    logic [SH_W-1:0] sh_s;
    logic [2:0]      s_s;
    logic [QW-1:0]   q_d;
    logic            sat_d;

    // b_q is held for the whole operation, so eb/bn/xt stay valid through SCALE.
    lod_normalize #(.N(N)) u_lod (
        .b_i  (b_q),
        .eb_o (eb_s),
        .bn_o (bn_s)
    );

    // x = 2^N - bn fits in N bits because bn >= 2^(N-1); then drop low N-NB bits.
    always_comb begin
        xt_s      = ({N{1'b0}} - bn_s) & XT_MASK;
        pow2_s    = (bn_s == {1'b1, {(N-1){1'b0}}});
        prod_it_s = (2*N)'(p_q) * (2*N)'(xt_s);
        p_next_s  = N'(prod_it_s >> N);
    end

    // Final scaling, correction and saturation.
    always_comb begin
        prod_s  = PW'(a_q) * PW'(acc_q);
        sh_s    = SH_W'(eb_s) + SH_W'(N - F_W);
        q_raw_s = prod_s >> sh_s;
        s_s     = corr_shift(32'(t_q));
        if (corr_q && !exact_pend_q && !dz_pend_q && (s_s != 3'd0)) begin
            q_cor_s = q_raw_s + (q_raw_s >> s_s);
        end else begin
            q_cor_s = q_raw_s;
        end
        if (dz_pend_q) begin
            q_d   = {QW{1'b1}};
            sat_d = 1'b0;
        end else if (q_cor_s > Q_MAX) begin
            q_d   = {QW{1'b1}};
            sat_d = 1'b1;
        end else begin
            q_d   = q_cor_s[QW-1:0];
            sat_d = 1'b0;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            t_q          <= '0;
            cnt_q        <= '0;
            p_q          <= '0;
            acc_q        <= '0;
            corr_q       <= 1'b0;
            dz_pend_q    <= 1'b0;
            exact_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            q_q          <= '0;
            dz_q         <= 1'b0;
            sat_q        <= 1'b0;
            exact_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        t_q     <= (32'(cycles) > 32'(MAX_T)) ? T_MAX : cycles;
                        corr_q  <= corr_en;
                        busy_q  <= 1'b1;
                        dz_q    <= 1'b0;
                        sat_q   <= 1'b0;
                        exact_q <= 1'b0;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    p_q          <= xt_s;
                    acc_q        <= AW'({1'b1, xt_s});
                    cnt_q        <= t_q;
                    dz_pend_q    <= (b_q == {N{1'b0}});
                    exact_pend_q <= pow2_s;
                    if (b_q == {N{1'b0}}) begin
                        state_q <= S_SCALE;
                    end else if (pow2_s) begin
                        acc_q   <= {1'b1, {(AW-1){1'b0}}};
                        state_q <= S_SCALE;
                    end else if (t_q == {T_W{1'b0}}) begin
                        state_q <= S_SCALE;
                    end else begin
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    p_q   <= p_next_s;
                    acc_q <= acc_q + AW'(p_next_s);
                    cnt_q <= cnt_q - T_W'(1);
                    if (cnt_q == T_W'(1)) begin
                        state_q <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    q_q     <= q_d;
                    sat_q   <= sat_d;
                    dz_q    <= dz_pend_q;
                    exact_q <= exact_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign q     = q_q;
    assign dz    = dz_q;
    assign sat   = sat_q;
    assign exact = exact_q;

endmodule

// File: tb/tb_approx_taylor_divider.sv
// Scoreboard bench: two divider instances (NB=8/MAX_T=15 and NB=4/MAX_T=12) share stimulus.
module tb_approx_taylor_divider;

    localparam int N   = 8;
    localparam int F_W = 8;

    typedef struct {
        logic [15:0] q;
        logic        dz;
        logic        sat;
        logic        exact;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic [3:0]  cycles = 4'd0;
    logic        corr_en = 1'b0;

    logic        busy1, done1, dz1, sat1, ex1;
    logic [15:0] q1;
    logic        busy2, done2, dz2, sat2, ex2;
    logic [15:0] q2;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_taylor_divider #(.N(8), .NB(8), .F_W(8), .MAX_T(15)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cycles(cycles),
        .corr_en(corr_en), .busy(busy1), .done(done1), .q(q1),
        .dz(dz1), .sat(sat1), .exact(ex1)
    );

    approx_taylor_divider #(.N(8), .NB(4), .F_W(8), .MAX_T(12)) dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cycles(cycles),
        .corr_en(corr_en), .busy(busy2), .done(done2), .q(q2),
        .dz(dz2), .sat(sat2), .exact(ex2)
    );

    // Reference: series 1 + xt + ... + xt^(T+1) with truncated terms, then scale and correct.
    function automatic exp_t model(int av, int bv, int tv, bit cv, int nb, int maxt, int c0);
        exp_t   e;
        longint acc, term, xt, bn, qq;
        int     eb, te, s;
        e.dz = 1'b0; e.sat = 1'b0; e.exact = 1'b0;
        te = (tv > maxt) ? maxt : tv;
        if (bv == 0) begin
            e.dz = 1'b1; e.q = 16'hFFFF; e.due = c0 + 3;
            return e;
        end
        eb = 0;
        for (int i = 0; i < N; i++) if (((bv >> i) & 1) != 0) eb = i + 1;
        if ((bv & (bv - 1)) == 0) begin
            e.exact = 1'b1;
            acc = 512;
            e.due = c0 + 3;
        end else begin
            bn = longint'(bv) << (N - eb);
            xt = ((256 - bn) >> (N - nb)) << (N - nb);
            acc = 256;
            term = 256;
            for (int k = 0; k <= te; k++) begin
                term = (term * xt) >> N;
                acc += term;
            end
            e.due = c0 + te + 3;
        end
        qq = (longint'(av) * acc) >> (N + eb - F_W);
        if (cv && !e.exact) begin
            s = (te == 0) ? 4 : (te <= 3) ? 6 : (te <= 6) ? 7 : 0;
            if (s != 0) qq += qq >> s;
        end
        if (qq > 65535) begin
            e.sat = 1'b1; e.q = 16'hFFFF;
        end else begin
            e.q = 16'(qq);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_done", 1, 0);
            end else begin
                e = sb1.pop_front();
                chk("dut1_q", q1, e.q);
                chk("dut1_dz", dz1, e.dz);
                chk("dut1_sat", sat1, e.sat);
                chk("dut1_exact", ex1, e.exact);
                chk("dut1_latency", cyc, e.due);
                chk("dut1_busy_at_done", busy1, 0);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2 === 1'b1) begin
            if (sb2.size() == 0) begin
                chk("dut2_unexpected_done", 1, 0);
            end else begin
                e = sb2.pop_front();
                chk("dut2_q", q2, e.q);
                chk("dut2_dz", dz2, e.dz);
                chk("dut2_sat", sat2, e.sat);
                chk("dut2_exact", ex2, e.exact);
                chk("dut2_latency", cyc, e.due);
                chk("dut2_busy_at_done", busy2, 0);
            end
        end
    end

    // Called just after a falling edge; poke re-asserts start with fresh operands while busy.
    task automatic issue(input int av, input int bv, input int tv, input bit cv,
                         input bit track, input bit poke);
        a = 8'(av); b = 8'(bv); cycles = 4'(tv); corr_en = cv; start = 1'b1;
        if (track) begin
            sb1.push_back(model(av, bv, tv, cv, 8, 15, cyc));
            sb2.push_back(model(av, bv, tv, cv, 4, 12, cyc));
        end
        @(negedge clk);
        chk("busy_after_accept", {busy1, busy2}, 2'b11);
        if (poke) begin
            a = 8'($urandom); b = 8'($urandom); cycles = 4'($urandom); corr_en = 1'($urandom);
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb1.size() != 0 || sb2.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (sb1.size() != 0 || sb2.size() != 0) begin
            chk("done_timeout", sb1.size() + sb2.size(), 0);
            sb1.delete();
            sb2.delete();
        end
    endtask

    initial begin
        int bv;
        repeat (3) @(negedge clk);
        chk("reset_busy", {busy1, busy2}, 0);
        chk("reset_done", {done1, done2}, 0);
        chk("reset_q", {q1, q2}, 0);
        chk("reset_flags", {dz1, sat1, ex1, dz2, sat2, ex2}, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        issue(1, 3, 3, 0, 1, 0);     drain();
        issue(1, 3, 3, 1, 1, 1);     drain();
        issue(200, 1, 5, 0, 1, 0);   drain();
        issue(17, 0, 9, 1, 1, 1);    drain();
        issue(255, 155, 0, 0, 1, 0); drain();
        issue(255, 155, 0, 1, 1, 0); drain();
        issue(255, 255, 15, 1, 1, 1); drain();
        issue(255, 129, 7, 1, 1, 0); drain();
        issue(0, 77, 4, 1, 1, 0);    drain();

        // Abort a long run with a one-cycle reset on its fifth edge.
        issue(1, 3, 10, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {busy1, busy2}, 0);
        chk("abort_done", {done1, done2}, 0);
        chk("abort_q", {q1, q2}, 0);
        chk("abort_flags", {dz1, sat1, ex1, dz2, sat2, ex2}, 0);
        rst = 1'b0;
        #1;
        issue(1, 3, 3, 0, 1, 0);     drain();

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       bv = 0;
                1, 2:    bv = 1 << $urandom_range(0, 7);
                default: bv = $urandom_range(1, 255);
            endcase
            issue($urandom_range(0, 255), bv, $urandom_range(0, 15),
                  1'($urandom), 1, 1'($urandom));
            drain();
        end

        repeat (20) @(negedge clk);
        chk("sb1_empty", sb1.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
